// File: rtl/huffman_pkg.sv
// Shared Huffman definitions for the encoder (bit packer) and decoder sides.
package huffman_pkg;
  localparam int SYM_W  = 8;
  localparam int CODE_W = 16;
  localparam int LEN_W  = 5;
  localparam int WORD_W = 32;
  localparam int ACC_W  = 48;
  localparam int FILL_W = 6;

  localparam logic [FILL_W-1:0] FULL_FILL = 6'd32;

  typedef enum logic [1:0] {RUN, FLUSH, LAST} state_e;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [LEN_W-1:0]  len;
  } cb_entry_t;

  // Mask keeping the top 'len' bits of an MSB-aligned codeword.
  function automatic logic [CODE_W-1:0] code_mask(input logic [LEN_W-1:0] len);
    logic [CODE_W-1:0] m;
    m = '0;
    for (int i = 0; i < CODE_W; i++)
      if (i < int'(len)) m[CODE_W-1-i] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/huffman_bit_packer_if.sv
// Symbol input, packed word output, codebook load and status signals.
// Stats signals exist only when HUFF_PACK_STATS_EN is defined.
interface huffman_bit_packer_if;
  import huffman_pkg::*;

  logic [SYM_W-1:0]  sym_in;
  logic              sym_valid;
  logic              sym_ready;
  logic              flush;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;
  logic              word_last;
  logic [5:0]        word_bits;
  logic              code_err;
  logic [SYM_W-1:0]  load_symbol;
  logic [CODE_W-1:0] load_code;
  logic [LEN_W-1:0]  load_length;
  logic              load_valid;
  logic              load_valid_out;
`ifdef HUFF_PACK_STATS_EN
  logic [31:0]       stat_symbols;
  logic [31:0]       stat_bits;
`endif

  modport master (
    output sym_in, sym_valid, flush, word_ready,
           load_symbol, load_code, load_length, load_valid,
    input  sym_ready, word_out, word_valid, word_last, word_bits,
           code_err, load_valid_out
`ifdef HUFF_PACK_STATS_EN
    , input stat_symbols, stat_bits
`endif
  );

  modport slave (
    input  sym_in, sym_valid, flush, word_ready,
           load_symbol, load_code, load_length, load_valid,
    output sym_ready, word_out, word_valid, word_last, word_bits,
           code_err, load_valid_out
`ifdef HUFF_PACK_STATS_EN
    , output stat_symbols, stat_bits
`endif
  );
endinterface

// File: rtl/huffman_codebook.sv
// Software-loaded codebook: write on the rising edge of load_valid,
// ack held until load_valid falls, asynchronous read by symbol.
module huffman_codebook
  import huffman_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [SYM_W-1:0]  load_symbol_i,
  input  logic [CODE_W-1:0] load_code_i,
  input  logic [LEN_W-1:0]  load_length_i,
  input  logic              load_valid_i,
  output logic              load_ack_o,
  output logic              load_edge_o,
  input  logic [SYM_W-1:0]  rd_sym_i,
  output cb_entry_t         rd_entry_o
);
  logic              lv_q;
  logic              ack_q;
  logic [CODE_W-1:0] code_mem [2**SYM_W];
  logic [LEN_W-1:0]  len_mem  [2**SYM_W];

  assign load_edge_o = load_valid_i & ~lv_q;
  assign load_ack_o  = ack_q;
  assign rd_entry_o  = '{code: code_mem[rd_sym_i], len: len_mem[rd_sym_i]};

  // Edge detector and acknowledge: set on the write, clear once load_valid drops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lv_q  <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      lv_q <= load_valid_i;
      if (load_edge_o)       ack_q <= 1'b1;
      else if (!load_valid_i) ack_q <= 1'b0;
    end
  end

  // Table storage; contents survive reset so software need not reload.
  always_ff @(posedge clock) begin
    if (load_edge_o) begin
      code_mem[load_symbol_i] <= load_code_i;
      len_mem[load_symbol_i]  <= load_length_i;
    end
  end
endmodule

// File: rtl/huffman_bit_packer.sv
// Huffman encoder: symbol -> codeword lookup, MSB-first packing into 32-bit
// words through a 48-bit accumulator, flush pads and tags the final word.
// Optional HUFF_PACK_STATS_EN adds saturating symbol/bit counters.
module huffman_bit_packer
  import huffman_pkg::*;
#(
  parameter int MAX_LEN = 16
) (
  input  logic clock,
  input  logic reset_n,
  huffman_bit_packer_if.slave bus
);
  cb_entry_t         ent;
  logic              load_edge;
  logic              load_ack;
  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d, fill_ns;
  logic [WORD_W-1:0] word_q;
  logic              wvld_q, wlast_q;
  logic [5:0]        wbits_q;
  logic              err_q;
  logic              alive_q;
  logic              out_free, emit_full, emit_last;
  logic              sym_ready, accept, legal, stream_done;
  logic [ACC_W-1:0]  app;

  huffman_codebook u_cb (
    .clock        (clock),
    .reset_n      (reset_n),
    .load_symbol_i(bus.load_symbol),
    .load_code_i  (bus.load_code),
    .load_length_i(bus.load_length),
    .load_valid_i (bus.load_valid),
    .load_ack_o   (load_ack),
    .load_edge_o  (load_edge),
    .rd_sym_i     (bus.sym_in),
    .rd_entry_o   (ent)
  );

  assign stream_done = (state_q == LAST) && wvld_q && bus.word_ready;

  // Emission decision, input backpressure and accumulator next state.
  always_comb begin
    out_free  = !wvld_q || bus.word_ready;
    emit_full = 1'b0;
    emit_last = 1'b0;
    if (out_free) begin
      if (state_q == RUN && fill_q >= FULL_FILL) emit_full = 1'b1;
      if (state_q == FLUSH) begin
        if (fill_q > FULL_FILL) emit_full = 1'b1;
        else                    emit_last = 1'b1;
      end
    end
    fill_ns   = emit_full ? fill_q - FULL_FILL : fill_q;
    // alive_q keeps ready low during and right after reset
    sym_ready = alive_q && (state_q == RUN) && !bus.load_valid && (fill_ns <= FULL_FILL);
    accept    = bus.sym_valid && sym_ready;
    legal     = (ent.len != '0) && (int'(ent.len) <= MAX_LEN);
    // place the codeword directly after the bits that remain post-emission
    app       = {ent.code & code_mask(ent.len), 32'b0} >> fill_ns;
    acc_d     = emit_full ? {acc_q[15:0], 32'b0} : acc_q;
    fill_d    = fill_ns;
    if (emit_last || stream_done) begin
      acc_d  = '0;
      fill_d = '0;
    end
    if (accept && legal) begin
      acc_d  = acc_d | app;
      fill_d = fill_ns + {1'b0, ent.len};
    end
  end

  // Next-state logic; a flush arriving with a symbol takes the symbol first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.flush)  state_d = FLUSH;
      FLUSH:   if (emit_last)  state_d = LAST;
      LAST:    if (stream_done) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State, accumulator and sticky error registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      acc_q   <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      alive_q <= 1'b1;
      if (accept && !legal) err_q <= 1'b1;
      else if (load_edge)   err_q <= 1'b0;
    end
  end

  // Output word register; contents frozen while stalled by word_ready.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word_q  <= '0;
      wvld_q  <= 1'b0;
      wlast_q <= 1'b0;
      wbits_q <= '0;
    end else if (emit_full || emit_last) begin
      word_q  <= acc_q[ACC_W-1 -: WORD_W];
      wvld_q  <= 1'b1;
      wlast_q <= emit_last;
      wbits_q <= emit_full ? FULL_FILL : fill_q;
    end else if (bus.word_ready) begin
      wvld_q  <= 1'b0;
      wlast_q <= 1'b0;
    end
  end

  assign bus.sym_ready      = sym_ready;
  assign bus.word_out       = word_q;
  assign bus.word_valid     = wvld_q;
  assign bus.word_last      = wlast_q;
  assign bus.word_bits      = wbits_q;
  assign bus.code_err       = err_q;
  assign bus.load_valid_out = load_ack;

`ifdef HUFF_PACK_STATS_EN
  logic [31:0] st_sym_q, st_bits_q;
  logic [32:0] bits_sum;

  assign bits_sum = {1'b0, st_bits_q} + 33'(ent.len);

  // Saturating per-stream counters of legal symbols and appended code bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_sym_q  <= '0;
      st_bits_q <= '0;
    end else if (stream_done) begin
      st_sym_q  <= '0;
      st_bits_q <= '0;
    end else if (accept && legal) begin
      if (st_sym_q != '1) st_sym_q <= st_sym_q + 32'd1;
      st_bits_q <= bits_sum[32] ? '1 : bits_sum[31:0];
    end
  end

  assign bus.stat_symbols = st_sym_q;
  assign bus.stat_bits    = st_bits_q;
`endif
endmodule

// File: tb/tb_huffman_bit_packer.sv
// Bench for huffman_bit_packer: table-driven short streams plus hand-written
// stall, error, mid-stream load and reset sequences; scoreboard of words.
module tb_huffman_bit_packer;
  import huffman_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  huffman_bit_packer_if bus();
  huffman_bit_packer dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));

  typedef struct { logic [31:0] word; logic [5:0] bits; logic last; } exp_t;
  typedef struct { int n; logic [0:3][7:0] s; logic [31:0] w; logic [5:0] b; } vec_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] tcode [256];
  logic [4:0]  tlen  [256];
  logic [63:0] mbuf = '0;
  int          mfill = 0;
  bit          bp_seen = 1'b0;
  bit          held = 1'b0;
  logic [31:0] held_word;
  logic [5:0]  held_bits;
  exp_t        e;
  vec_t        vt [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference packer: append code bits, emit whole words as they form.
  task automatic m_append(input logic [7:0] s);
    logic [15:0] cm;
    logic [63:0] v;
    if (tlen[s] == 0 || tlen[s] > 16) return;
    cm = tcode[s] & (16'hFFFF << (16 - tlen[s]));
    v  = {cm, 48'b0};
    mbuf  = mbuf | (v >> mfill);
    mfill = mfill + int'(tlen[s]);
    if (mfill >= 32) begin
      sbq.push_back('{mbuf[63:32], 6'd32, 1'b0});
      mbuf  = mbuf << 32;
      mfill = mfill - 32;
    end
  endtask

  // Word monitor: hold-stability check and scoreboard compare on handshake.
  always @(negedge clock) begin
    if (!reset_n) held = 1'b0;
    else begin
      if (held && bus.word_valid) begin
        chk("hold_word", bus.word_out, held_word);
        chk("hold_bits", 32'(bus.word_bits), 32'(held_bits));
      end
      held      = bus.word_valid && !bus.word_ready;
      held_word = bus.word_out;
      held_bits = bus.word_bits;
      if (bus.word_valid && bus.word_ready) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %h expected none", bus.word_out);
        end else begin
          e = sbq.pop_front();
          chk("word_out", bus.word_out, e.word);
          chk("word_bits", 32'(bus.word_bits), 32'(e.bits));
          chk("word_last", 32'(bus.word_last), 32'(e.last));
        end
      end
    end
  end

  task automatic load(input logic [7:0] s, input logic [15:0] c, input logic [4:0] l);
    bit got;
    bus.load_symbol = s; bus.load_code = c; bus.load_length = l; bus.load_valid = 1'b1;
    tcode[s] = c; tlen[s] = l;
    got = 1'b0;
    @(negedge clock);
    chk("ready_during_load", 32'(bus.sym_ready), 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (bus.load_valid_out) begin got = 1'b1; break; end
      @(negedge clock);
    end
    chk("load_ack_rise", 32'(got), 32'd1);
    @(posedge clock); #1;
    bus.load_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (!bus.load_valid_out) begin got = 1'b1; break; end
    end
    chk("load_ack_fall", 32'(got), 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic send(input logic [7:0] s);
    bit ok;
    ok = 1'b0;
    bus.sym_in = s; bus.sym_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      ok = bus.sym_ready;
      if (!ok) bp_seen = 1'b1;
      @(posedge clock); #1;
      if (ok) break;
    end
    bus.sym_valid = 1'b0;
    if (ok) m_append(s);
    else begin
      checks++; errors++;
      $display("FAIL send_timeout: got no sym_ready expected ready for %h", s);
    end
  endtask

  task automatic do_flush(input bit tbl, input logic [31:0] w, input logic [5:0] b);
    bus.flush = 1'b1;
    @(posedge clock); #1;
    bus.flush = 1'b0;
    if (tbl) sbq.push_back('{w, b, 1'b1});
    else     sbq.push_back('{mbuf[63:32], 6'(mfill), 1'b1});
    mbuf = '0; mfill = 0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (sbq.size() == 0) break;
      @(posedge clock); #1;
    end
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", sbq.size());
      sbq.delete();
    end
    @(posedge clock); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sym_ready"},  32'(bus.sym_ready), 32'd0);
    chk({tag, "_word_out"},   bus.word_out, 32'd0);
    chk({tag, "_word_valid"}, 32'(bus.word_valid), 32'd0);
    chk({tag, "_word_last"},  32'(bus.word_last), 32'd0);
    chk({tag, "_word_bits"},  32'(bus.word_bits), 32'd0);
    chk({tag, "_code_err"},   32'(bus.code_err), 32'd0);
    chk({tag, "_load_ack"},   32'(bus.load_valid_out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{3, {8'h41, 8'h42, 8'h43, 8'h00}, 32'h58000000, 6'd5};
    vt[1] = '{4, {8'h43, 8'h43, 8'h41, 8'h42}, 32'hF4000000, 6'd7};
    vt[2] = '{1, {8'h00, 8'h00, 8'h00, 8'h00}, 32'hABCD0000, 6'd16};
    vt[3] = '{2, {8'h41, 8'h00, 8'h00, 8'h00}, 32'h55E68000, 6'd17};
    vt[4] = '{0, {8'h00, 8'h00, 8'h00, 8'h00}, 32'h00000000, 6'd0};
    vt[5] = '{2, {8'h00, 8'h42, 8'h00, 8'h00}, 32'hABCD8000, 6'd18};
    vt[6] = '{3, {8'h45, 8'h45, 8'h43, 8'h00}, 32'h99C00000, 6'd10};

    bus.sym_in = '0; bus.sym_valid = 1'b0; bus.flush = 1'b0; bus.word_ready = 1'b1;
    bus.load_symbol = '0; bus.load_code = '0; bus.load_length = '0; bus.load_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_reset_outputs("rst");
    reset_n = 1'b1;
    @(posedge clock); #1;

    load(8'h41, 16'h0000, 5'd1);
    load(8'h42, 16'h8000, 5'd2);
    load(8'h43, 16'hC000, 5'd2);
    load(8'h00, 16'hABCD, 5'd16);
    load(8'h45, 16'h9000, 5'd4);
    load(8'h46, 16'hFFFF, 5'd0);

    // A,B,C then flush: a single padded last word, stats visible until LAST->RUN
    send(8'h41); send(8'h42); send(8'h43);
    do_flush(1'b1, 32'h58000000, 6'd5);
`ifdef HUFF_PACK_STATS_EN
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clock);
        if (bus.word_valid && bus.word_last) begin seen = 1'b1; break; end
      end
      chk("last_seen", 32'(seen), 32'd1);
      chk("stat_symbols_pre", bus.stat_symbols, 32'd3);
      chk("stat_bits_pre", bus.stat_bits, 32'd5);
      @(posedge clock); #1;
    end
`endif
    wait_drain();
`ifdef HUFF_PACK_STATS_EN
    chk("stat_symbols_post", bus.stat_symbols, 32'd0);
    chk("stat_bits_post", bus.stat_bits, 32'd0);
`endif

    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < vt[v].n; k++) send(vt[v].s[k]);
      do_flush(1'b1, vt[v].w, vt[v].b);
      wait_drain();
    end

    // two full-length codes make exactly one word, then an empty last word
    send(8'h00); send(8'h00);
    wait_drain();
    do_flush(1'b0, 32'h0, 6'd0);
    wait_drain();

    // output stall after the first word: backpressure, held word, no loss
    bp_seen = 1'b0;
    fork
      for (int k = 0; k < 8; k++) send(8'h00);
      begin
        for (int i = 0; i < 50; i++) begin
          @(negedge clock);
          if (bus.word_valid) break;
        end
        @(posedge clock); #1;
        bus.word_ready = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        bus.word_ready = 1'b1;
      end
    join
    chk("backpressure_seen", 32'(bp_seen), 32'd1);
    wait_drain();
    do_flush(1'b0, 32'h0, 6'd0);
    wait_drain();

    // zero-length code is dropped and flags a sticky error
    send(8'h46); send(8'h41);
    chk("code_err_set", 32'(bus.code_err), 32'd1);
    do_flush(1'b0, 32'h0, 6'd0);
    wait_drain();
    chk("code_err_sticky", 32'(bus.code_err), 32'd1);
    load(8'h47, 16'hF000, 5'd4);
    chk("code_err_clear", 32'(bus.code_err), 32'd0);

    // load between symbols keeps the accumulator contents
    send(8'h41);
    load(8'h48, 16'h5000, 5'd4);
    send(8'h42);
    do_flush(1'b1, 32'h40000000, 6'd3);
    wait_drain();

    // reset mid-stream with fill=20 and a stalled word pending
    bus.word_ready = 1'b0;
    send(8'h00); send(8'h00); send(8'h00); send(8'h45);
    chk("pre_reset_word_valid", 32'(bus.word_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    sbq.delete(); mbuf = '0; mfill = 0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    bus.word_ready = 1'b1;
    @(posedge clock); #1;
    send(8'h41); send(8'h42); send(8'h43);
    do_flush(1'b1, 32'h58000000, 6'd5);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
